// File: rtl/dmem_pkg.sv
// Shared definitions for the sized data memory: size encodings, FSM states
// and the access-size byte count helper.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      SZ_BYTE: return 3'd1;
      SZ_HALF: return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational big-endian lane steering, load extension and access checks.
// DMEM_MISALIGN_TRAP_EN: misaligned half/word accesses error instead of being aligned down.
module dmem_lane_align
  import dmem_pkg::*;
#(
  parameter int DEPTH_BYTES = 1024,
  parameter int ADDR_W      = 32,
  parameter int IDX_W       = $clog2(DEPTH_BYTES)
) (
  input  logic [1:0]        size,
  input  logic              is_signed,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  input  logic [31:0]       rword,
  output logic [IDX_W-1:0]  base_idx,
  output logic [31:0]       wword,
  output logic [3:0]        be,
  output logic [31:0]       rdata,
  output logic              err
);

  logic [ADDR_W:0] last_addr;
  logic            range_err;
  logic            align_err;

  // Range is judged on the raw address, before any alignment clearing.
  assign last_addr = {1'b0, addr} + (ADDR_W+1)'(size_bytes(size)) - (ADDR_W+1)'(1);
  assign range_err = last_addr >= (ADDR_W+1)'(DEPTH_BYTES);

`ifdef DMEM_MISALIGN_TRAP_EN
  assign align_err = ((size == SZ_HALF) && addr[0]) ||
                     ((size == SZ_WORD) && (addr[1:0] != 2'b00));
  assign base_idx  = addr[IDX_W-1:0];
`else
  assign align_err = 1'b0;
  always_comb begin
    base_idx = addr[IDX_W-1:0];
    if (size == SZ_HALF) base_idx[0] = 1'b0;
    if (size == SZ_WORD) base_idx[1:0] = 2'b00;
  end
`endif

  assign err = (size == SZ_RSVD) || range_err || align_err;

  // rword/wword lay byte offset 0 in [31:24]; be[i] enables offset i.
  always_comb begin
    rdata = 32'd0;
    wword = 32'd0;
    be    = 4'b0000;
    case (size)
      SZ_BYTE: begin
        rdata = {{24{is_signed & rword[31]}}, rword[31:24]};
        wword = {wdata[7:0], 24'd0};
        be    = 4'b0001;
      end
      SZ_HALF: begin
        rdata = {{16{is_signed & rword[31]}}, rword[31:16]};
        wword = {wdata[15:0], 16'd0};
        be    = 4'b0011;
      end
      SZ_WORD: begin
        rdata = rword;
        wword = wdata;
        be    = 4'b1111;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/sized_data_memory.sv
// Byte-addressed big-endian data memory with byte/half/word access and a
// valid/ready port with configurable latency. Honours DMEM_MISALIGN_TRAP_EN.
//
// state | meaning
// IDLE  | no request in flight, ready
// WAIT  | request accepted, counting down to the commit edge
// RESP  | response valid this cycle, ready for the next request
module sized_data_memory
  import dmem_pkg::*;
#(
  parameter int    DEPTH_BYTES = 1024,
  parameter int    ADDR_W      = 32,
  parameter int    LATENCY     = 1,
  parameter string INIT_FILE   = ""
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err
);

  localparam int IDX_W = $clog2(DEPTH_BYTES);

  logic [7:0] mem [DEPTH_BYTES];

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic        accept, commit;

  logic              cap_write, cap_signed;
  logic [1:0]        cap_size;
  logic [ADDR_W-1:0] cap_addr;
  logic [31:0]       cap_wdata;

  logic              act_write, act_signed;
  logic [1:0]        act_size;
  logic [ADDR_W-1:0] act_addr;
  logic [31:0]       act_wdata;

  logic [IDX_W-1:0]  base_idx;
  logic [31:0]       rword, wword, rdata_al;
  logic [3:0]        be;
  logic              err;

  assign req_ready  = (state == IDLE) || (state == RESP);
  assign resp_valid = (state == RESP);
  assign accept     = req_valid && req_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    commit    = 1'b0;
    case (state)
      IDLE, RESP: begin
        state_nxt = IDLE;
        if (accept) begin
          if (LATENCY == 1) begin
            state_nxt = RESP;
            commit    = 1'b1;
          end else begin
            state_nxt = WAIT;
            cnt_nxt   = 4'(LATENCY - 1);
          end
        end
      end
      WAIT: begin
        if (cnt <= 4'd1) begin
          state_nxt = RESP;
          cnt_nxt   = 4'd0;
          commit    = 1'b1;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_write  <= 1'b0;
      cap_size   <= SZ_BYTE;
      cap_signed <= 1'b0;
      cap_addr   <= '0;
      cap_wdata  <= 32'd0;
    end else if (accept) begin
      cap_write  <= req_write;
      cap_size   <= req_size;
      cap_signed <= req_signed;
      cap_addr   <= req_addr;
      cap_wdata  <= req_wdata;
    end
  end

  // With single-edge latency the accept edge is also the commit edge.
  assign act_write  = (LATENCY == 1) ? req_write  : cap_write;
  assign act_size   = (LATENCY == 1) ? req_size   : cap_size;
  assign act_signed = (LATENCY == 1) ? req_signed : cap_signed;
  assign act_addr   = (LATENCY == 1) ? req_addr   : cap_addr;
  assign act_wdata  = (LATENCY == 1) ? req_wdata  : cap_wdata;

  dmem_lane_align #(
    .DEPTH_BYTES(DEPTH_BYTES),
    .ADDR_W     (ADDR_W),
    .IDX_W      (IDX_W)
  ) u_align (
    .size     (act_size),
    .is_signed(act_signed),
    .addr     (act_addr),
    .wdata    (act_wdata),
    .rword    (rword),
    .base_idx (base_idx),
    .wword    (wword),
    .be       (be),
    .rdata    (rdata_al),
    .err      (err)
  );

  always_comb begin
    rword = 32'd0;
    for (int i = 0; i < 4; i++) begin
      rword[31-8*i -: 8] = mem[base_idx + IDX_W'(i)];
    end
  end

  always_ff @(posedge clk) begin
    if (commit && act_write && !err) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[base_idx + IDX_W'(i)] <= wword[31-8*i -: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
    end else if (commit) begin
      resp_rdata <= (act_write || err) ? 32'd0 : rdata_al;
      resp_err   <= err;
    end
  end

endmodule

// File: tb/tb_sized_data_memory.sv
// Bench for sized_data_memory: a LATENCY=1 and a LATENCY=3 instance checked
// against a byte-array reference model; DMEM_MISALIGN_TRAP_EN selects the expected policy.
module tb_sized_data_memory;
  import dmem_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0]       req_valid = '0, req_ready, req_write = '0, req_signed = '0;
  logic [1:0]       resp_valid, resp_err;
  logic [1:0][1:0]  req_size = '0;
  logic [1:0][31:0] req_addr = '0, req_wdata = '0, resp_rdata;

  int n_cmp = 0;
  int n_bad = 0;
  byte unsigned mm [2][1024];

  sized_data_memory #(.DEPTH_BYTES(1024), .ADDR_W(32), .LATENCY(1), .INIT_FILE("")) u_lat1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
    .req_size(req_size[0]), .req_signed(req_signed[0]), .req_addr(req_addr[0]),
    .req_wdata(req_wdata[0]), .resp_valid(resp_valid[0]), .resp_rdata(resp_rdata[0]),
    .resp_err(resp_err[0])
  );

  sized_data_memory #(.DEPTH_BYTES(1024), .ADDR_W(32), .LATENCY(3), .INIT_FILE("")) u_lat3 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
    .req_size(req_size[1]), .req_signed(req_signed[1]), .req_addr(req_addr[1]),
    .req_wdata(req_wdata[1]), .resp_valid(resp_valid[1]), .resp_rdata(resp_rdata[1]),
    .resp_err(resp_err[1])
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: memory as a plain byte array, big-endian, value built arithmetically.
  task automatic model(input int d, input bit wr, input int sz, input bit sg,
                       input logic [31:0] addr, input logic [31:0] wd,
                       output logic [31:0] rd, output bit er);
    int n;
    longint unsigned a, v;
    n  = (sz == 0) ? 1 : (sz == 1) ? 2 : (sz == 2) ? 4 : 0;
    er = 1'b0;
    rd = 32'd0;
    a  = longint'(addr);
    if (n == 0) er = 1'b1;
    else begin
      if (a + longint'(n) > 1024) er = 1'b1;
`ifdef DMEM_MISALIGN_TRAP_EN
      if (a % longint'(n) != 0) er = 1'b1;
`else
      a = a - a % longint'(n);
`endif
    end
    if (!er) begin
      if (wr) begin
        for (int i = 0; i < n; i++)
          mm[d][int'(a) + i] = byte'((wd >> (8 * (n - 1 - i))) & 32'hFF);
      end else begin
        v = 0;
        for (int i = 0; i < n; i++) v = v * 256 + longint'(mm[d][int'(a) + i]);
        if (sg && v >= (64'd1 << (8 * n - 1))) v = v + (64'd1 << 32) - (64'd1 << (8 * n));
        rd = v[31:0];
      end
    end
  endtask

  task automatic access(input int d, input bit wr, input int sz, input bit sg,
                        input logic [31:0] addr, input logic [31:0] wd,
                        output logic [31:0] o_rd, output logic o_er);
    int lat;
    logic [31:0] e_rd;
    bit e_er;
    lat = (d == 0) ? 1 : 3;
    model(d, wr, sz, sg, addr, wd, e_rd, e_er);
    chk("ready_at_issue", 32'(req_ready[d]), 32'd1);
    req_valid[d]  = 1'b1;
    req_write[d]  = wr;
    req_size[d]   = 2'(sz);
    req_signed[d] = sg;
    req_addr[d]   = addr;
    req_wdata[d]  = wd;
    @(posedge clk);
    @(negedge clk);
    req_valid[d]  = 1'b0;
    req_write[d]  = 1'($urandom);
    req_size[d]   = 2'($urandom);
    req_signed[d] = 1'($urandom);
    req_addr[d]   = $urandom;
    req_wdata[d]  = $urandom;
    for (int k = 1; k <= lat; k++) begin
      if (k > 1) @(negedge clk);
      if (k < lat) begin
        chk("wait_resp_valid", 32'(resp_valid[d]), 32'd0);
        chk("wait_req_ready", 32'(req_ready[d]), 32'd0);
      end else begin
        chk("resp_valid", 32'(resp_valid[d]), 32'd1);
        chk("resp_rdata", resp_rdata[d], e_rd);
        chk("resp_err", 32'(resp_err[d]), 32'(e_er));
      end
    end
    o_rd = resp_rdata[d];
    o_er = resp_err[d];
  endtask

  task automatic idle(input int d);
    @(negedge clk);
    chk("idle_resp_valid", 32'(resp_valid[d]), 32'd0);
    chk("idle_req_ready", 32'(req_ready[d]), 32'd1);
  endtask

  task automatic directed(input int d);
    logic [31:0] r;
    logic e;
    access(d, 1, 2, 0, 32'h10, 32'h12345678, r, e);
    access(d, 0, 2, 0, 32'h10, 32'h0, r, e);
    chk("tp_word_load", r, 32'h12345678);
    chk("tp_word_err", 32'(e), 32'd0);
    access(d, 0, 0, 0, 32'h10, 32'h0, r, e);
    chk("tp_byte_unsigned", r, 32'h00000012);
    access(d, 1, 0, 0, 32'h20, 32'hFFFFFF00, r, e);
    access(d, 1, 0, 0, 32'h21, 32'h00000080, r, e);
    access(d, 0, 0, 1, 32'h21, 32'h0, r, e);
    chk("tp_byte_signed", r, 32'hFFFFFF80);
    access(d, 0, 0, 0, 32'h21, 32'h0, r, e);
    chk("tp_byte_zext", r, 32'h00000080);
    access(d, 0, 1, 1, 32'h20, 32'h0, r, e);
    chk("tp_half_signed", r, 32'h00000080);
    idle(d);
    access(d, 0, 2, 0, 32'h3FE, 32'h0, r, e);
    chk("tp_range_err", 32'(e), 32'd1);
    chk("tp_range_rdata", r, 32'd0);
    access(d, 1, 2, 0, 32'h3FE, 32'hAAAAAAAA, r, e);
    access(d, 1, 3, 0, 32'h10, 32'hFFFFFFFF, r, e);
    chk("tp_rsvd_err", 32'(e), 32'd1);
    access(d, 0, 2, 0, 32'h10, 32'h0, r, e);
    chk("tp_rsvd_nowrite", r, 32'h12345678);
    access(d, 0, 2, 0, 32'h3FC, 32'h0, r, e);
    access(d, 1, 1, 0, 32'h31, 32'h0000A5C3, r, e);
`ifdef DMEM_MISALIGN_TRAP_EN
    chk("tp_misalign_err", 32'(e), 32'd1);
    access(d, 0, 2, 0, 32'h30, 32'h0, r, e);
`else
    chk("tp_misalign_err", 32'(e), 32'd0);
    access(d, 0, 1, 0, 32'h30, 32'h0, r, e);
    chk("tp_misalign_clear", r, 32'h0000A5C3);
`endif
    idle(d);
  endtask

  initial begin
    logic [31:0] r;
    logic e;
    logic [31:0] a;

    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_resp_valid", 32'(resp_valid[d]), 32'd0);
      chk("rst_resp_rdata", resp_rdata[d], 32'd0);
      chk("rst_resp_err", 32'(resp_err[d]), 32'd0);
      chk("rst_req_ready", 32'(req_ready[d]), 32'd1);
    end
    rst_n = 1'b1;
    @(negedge clk);

    for (int d = 0; d < 2; d++)
      for (int w = 0; w < 256; w++)
        access(d, 1, 2, 0, 32'(w * 4), $urandom, r, e);

    directed(0);
    directed(1);

    // Reset while a store is pending in WAIT drops the store.
    idle(1);
    chk("rst_issue_ready", 32'(req_ready[1]), 32'd1);
    req_valid[1] = 1'b1; req_write[1] = 1'b1; req_size[1] = SZ_WORD;
    req_signed[1] = 1'b0; req_addr[1] = 32'h40; req_wdata[1] = 32'hDEADBEEF;
    @(posedge clk);
    @(negedge clk);
    req_valid[1] = 1'b0;
    chk("rst_in_wait_ready", 32'(req_ready[1]), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_ready", 32'(req_ready[1]), 32'd1);
    chk("rst_mid_valid", 32'(resp_valid[1]), 32'd0);
    chk("rst_mid_rdata", resp_rdata[1], 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) idle(1);
    access(1, 0, 2, 0, 32'h40, 32'h0, r, e);

    for (int d = 0; d < 2; d++) begin
      for (int n = 0; n < 150; n++) begin
        case ($urandom_range(0, 3))
          0:       a = $urandom;
          1:       a = 32'($urandom_range(1016, 1031));
          default: a = 32'($urandom_range(0, 1023));
        endcase
        access(d, 1'($urandom), int'($urandom_range(0, 3)), 1'($urandom), a, $urandom, r, e);
        if ($urandom_range(0, 3) == 0) idle(d);
      end
    end

    for (int d = 0; d < 2; d++)
      for (int w = 0; w < 256; w++)
        access(d, 0, 2, 0, 32'(w * 4), 32'h0, r, e);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
